instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous and active-low (rst=0 at a rising edge resets the block).
REQ-004 Port fetch_en  input  1  permits fetching when high.
REQ-005 Port imem_adr  output  32  is the word-aligned fetch address to the combinational instruction memory.
REQ-006 Port imem_data  input  32  is the instruction word returned for imem_adr in the same cycle.
REQ-007 Port br_taken  input  1  requests a redirect to the branch target.
REQ-008 Port jmp  input  1  requests a redirect to the jump target.
REQ-009 Port redir_base  input  32  is PC+4 of the redirecting instruction.
REQ-010 Port br_imm  input  16  is the signed branch word offset.
REQ-011 Port jmp_idx  input  26  is the jump word index.
REQ-012 Port out_valid  output  1  flags a valid instruction on inst/inst_pc.
REQ-013 Port out_ready  input  1  means the downstream stage accepts the output this cycle.
REQ-014 Port inst  output  32  is the registered instruction word.
REQ-015 Port inst_pc  output  32  is the address inst was fetched from.
REQ-016 Port pc_plus4  output  32  equals inst_pc+4, mod 2^32.
REQ-017 Port fetch_cnt  output  32  counts instructions accepted downstream.

Function
REQ-018 The FSM shall have two states: IDLE (no fetch) and RUN (fetch).
REQ-019 IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; transitions happen at the clock edge.
REQ-020 imem_adr shall always equal the PC register.
REQ-021 Load condition: state=RUN and (out_valid=0 or out_ready=1) and no redirect.
REQ-022 On load: inst<=imem_data, inst_pc<=PC, out_valid<=1, PC<=PC+4; so out_valid rises 1 cycle after the address is issued.
REQ-023 Hold: out_valid=1 and out_ready=0 -> inst, inst_pc, out_valid and PC all unchanged.
REQ-024 Consume without load (out_valid=1, out_ready=1, no load) -> out_valid<=0.
REQ-025 Redirect = br_taken or jmp; it is accepted in IDLE or RUN.
REQ-026 Redirect priority: jmp over br_taken.
REQ-027 Branch target = redir_base + (sign_extend(br_imm) << 2), mod 2^32.
REQ-028 Jump target = {redir_base[31:28], jmp_idx, 2'b00}.
REQ-029 On redirect: PC<=target, out_valid<=0 (flush), and no load that cycle; the output held that cycle counts as consumed only if out_ready=1.
REQ-030 The first load after a redirect shall happen on the next RUN cycle, so the target instruction is valid 2 cycles after the redirect cycle.
REQ-031 Targets with bits [1:0]!=0 shall be forced to bits [1:0]=2'b00.
REQ-032 PC shall wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-033 fetch_cnt shall increment by 1 on each cycle with out_valid=1 and out_ready=1, including a redirect cycle, and shall wrap at 2^32.
REQ-034 Entering IDLE shall keep any held instruction valid until it is consumed or flushed.

Reset
REQ-035 With rst=0 at a clock edge: PC<=RESET_PC, state<=IDLE, out_valid<=0, inst<=0, inst_pc<=0, fetch_cnt<=0.
REQ-036 Reset overrides redirect, load and handshake in the same cycle; reset mid-hold drops the held instruction.
REQ-037 pc_plus4 shall read 32'h4 while reset is applied.

Verification
REQ-038 Reset release, fetch_en=1, out_ready=1, memory holding words W0..W3 -> inst=W0 one cycle after entering RUN, then W1, W2, W3 on consecutive cycles; inst_pc=0,4,8,12; fetch_cnt=4.
REQ-039 out_ready=0 for 3 cycles while inst_pc=8 -> inst, inst_pc and imem_adr=12 stay stable; release -> next inst_pc=12 with no skipped or duplicated word.
REQ-040 br_taken=1, redir_base=24, br_imm=-6 -> imem_adr=0 next cycle, out_valid=0 that cycle, inst_pc=0 one cycle later.
REQ-041 jmp=1 and br_taken=1 together, redir_base=32'h1000_0010, jmp_idx=26'h10 -> PC=32'h1000_0040 (jump wins).
REQ-042 PC=32'hFFFF_FFFC, load -> inst_pc=32'hFFFF_FFFC, pc_plus4=0, next imem_adr=0.
REQ-043 rst=0 for one cycle while out_valid=1 and out_ready=0 -> out_valid=0, PC=RESET_PC, fetch_cnt=0 at the next edge.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bundle: instruction memory, redirect and output stream
//
// Signals (master = fetch unit, slave = environment):
//   imem_adr   fetch unit -> memory   word-aligned fetch address
//   imem_data  memory -> fetch unit   instruction word for imem_adr, same cycle
//   fetch_en   env -> fetch unit      permits fetching
//   br_taken   env -> fetch unit      redirect to branch target
//   jmp        env -> fetch unit      redirect to jump target (wins over br_taken)
//   redir_base env -> fetch unit      PC+4 of the redirecting instruction
//   br_imm     env -> fetch unit      signed branch word offset
//   jmp_idx    env -> fetch unit      jump word index
//   out_valid  fetch unit -> env      inst/inst_pc hold a valid instruction
//   out_ready  env -> fetch unit      downstream accepts the output this cycle
//   inst       fetch unit -> env      registered instruction word
//   inst_pc    fetch unit -> env      address inst was fetched from
//   pc_plus4   fetch unit -> env      inst_pc + 4
//   fetch_cnt  fetch unit -> env      count of instructions accepted downstream
interface instr_fetch_if;
   logic [31:0] imem_adr;
   logic [31:0] imem_data;
   logic        fetch_en;
   logic        br_taken;
   logic        jmp;
   logic [31:0] redir_base;
   logic [15:0] br_imm;
   logic [25:0] jmp_idx;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc_plus4;
   logic [31:0] fetch_cnt;

   modport master (
      input  imem_data, fetch_en, br_taken, jmp, redir_base, br_imm, jmp_idx, out_ready,
      output imem_adr, out_valid, inst, inst_pc, pc_plus4, fetch_cnt
   );

   modport slave (
      output imem_data, fetch_en, br_taken, jmp, redir_base, br_imm, jmp_idx, out_ready,
      input  imem_adr, out_valid, inst, inst_pc, pc_plus4, fetch_cnt
   );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with branch/jump redirect and output handshake
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  instr_fetch_if.master: memory address/data, redirect inputs, output stream
//        (inst, inst_pc, pc_plus4 with out_valid/out_ready) and accepted-instruction count
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] target;
   logic        redirect;
   logic        consume;
   logic        load;
   logic        out_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] fetch_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      redirect  = bus.br_taken | bus.jmp;
      consume   = out_valid & bus.out_ready;
      target    = 32'h0;
      pc_nxt    = pc;
      load      = 1'b0;

      case (state)
         IDLE:    if (bus.fetch_en)  state_nxt = RUN;
         RUN:     if (!bus.fetch_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (bus.jmp)
         target = {bus.redir_base[31:28], bus.jmp_idx, 2'b00};
      else
         target = bus.redir_base + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};

      // A fresh word may be captured only when the output slot is empty or
      // being drained this cycle; a redirect always suppresses the capture.
      load = (state == RUN) && (!out_valid || bus.out_ready) && !redirect;

      if (redirect)
         pc_nxt = target & 32'hFFFF_FFFC;
      else if (load)
         pc_nxt = pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         inst      <= 32'h0;
         inst_pc   <= 32'h0;
         fetch_cnt <= 32'h0;
      end else begin
         // The handshake completes even on a redirect cycle.
         if (consume)
            fetch_cnt <= fetch_cnt + 32'd1;

         if (redirect) begin
            out_valid <= 1'b0;
         end else if (load) begin
            out_valid <= 1'b1;
            inst      <= bus.imem_data;
            inst_pc   <= pc;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.imem_adr  = pc;
   assign bus.out_valid = out_valid;
   assign bus.inst      = inst;
   assign bus.inst_pc   = inst_pc;
   assign bus.fetch_cnt = fetch_cnt;
   // inst_pc is zero once reset has been applied; forcing 4 covers the reset cycle itself.
   assign bus.pc_plus4  = rst ? (inst_pc + 32'd4) : 32'h4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a behavioural model
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] adr);
      return (adr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign bus.imem_data = mem_word(bus.imem_adr);

   // reference state
   logic [31:0] m_pc;
   logic        m_run;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_inst_pc;
   logic [31:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock: predict from the currently applied inputs, clock, then compare.
   task automatic cycle();
      logic [31:0] n_pc, n_inst, n_inst_pc, n_cnt, tgt;
      logic        n_run, n_valid, accepted;
      n_pc = m_pc; n_run = m_run; n_valid = m_valid;
      n_inst = m_inst; n_inst_pc = m_inst_pc; n_cnt = m_cnt;
      if (!rst) begin
         n_pc = RESET_PC; n_run = 1'b0; n_valid = 1'b0;
         n_inst = 32'h0; n_inst_pc = 32'h0; n_cnt = 32'h0;
      end else begin
         accepted = m_valid && bus.out_ready;
         if (accepted) n_cnt = m_cnt + 1;
         if (bus.jmp || bus.br_taken) begin
            if (bus.jmp)
               tgt = {bus.redir_base[31:28], 28'h0} + {4'h0, bus.jmp_idx, 2'b00};
            else
               tgt = bus.redir_base + 32'($signed(bus.br_imm)) * 32'd4;
            n_pc    = tgt - (tgt % 4);
            n_valid = 1'b0;
         end else if (m_run && (!m_valid || bus.out_ready)) begin
            n_inst    = mem_word(m_pc);
            n_inst_pc = m_pc;
            n_valid   = 1'b1;
            n_pc      = m_pc + 4;
         end else if (accepted) begin
            n_valid = 1'b0;
         end
         n_run = bus.fetch_en;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_run = n_run; m_valid = n_valid;
      m_inst = n_inst; m_inst_pc = n_inst_pc; m_cnt = n_cnt;
      check("imem_adr",  bus.imem_adr,  m_pc);
      check("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
      check("inst",      bus.inst,      m_inst);
      check("inst_pc",   bus.inst_pc,   m_inst_pc);
      check("pc_plus4",  bus.pc_plus4,  rst ? m_inst_pc + 4 : 32'h4);
      check("fetch_cnt", bus.fetch_cnt, m_cnt);
   endtask

   task automatic drive(input logic fe, input logic rdy, input logic bt, input logic jp,
                        input logic [31:0] base, input logic [15:0] imm, input logic [25:0] idx);
      bus.fetch_en = fe; bus.out_ready = rdy; bus.br_taken = bt; bus.jmp = jp;
      bus.redir_base = base; bus.br_imm = imm; bus.jmp_idx = idx;
   endtask

   initial begin
      m_pc = 'x; m_run = 1'b0; m_valid = 1'b0; m_inst = 'x; m_inst_pc = 'x; m_cnt = 'x;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);

      // reset state
      rst = 1'b0;
      cycle();
      check("rst_pc4", bus.pc_plus4, 32'h4);
      check("rst_adr", bus.imem_adr, RESET_PC);
      rst = 1'b1;

      // sequential fetch W0..W3
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
      cycle();
      check("seq_not_yet_valid", {31'h0, bus.out_valid}, 32'h0);
      cycle();
      check("seq_w0", bus.inst, mem_word(32'h0));
      cycle();
      cycle();
      check("seq_pc8", bus.inst_pc, 32'h8);

      // stall 3 cycles at inst_pc=8
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("hold_pc", bus.inst_pc, 32'h8);
         check("hold_adr", bus.imem_adr, 32'hC);
      end
      bus.out_ready = 1'b1;
      cycle();
      check("release_pc12", bus.inst_pc, 32'hC);
      check("release_w3", bus.inst, mem_word(32'hC));
      cycle();
      check("cnt4", bus.fetch_cnt, 32'd4);

      // branch back to 0
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd24, 16'hFFFA, 26'h0);
      cycle();
      check("br_adr", bus.imem_adr, 32'h0);
      check("br_flush", {31'h0, bus.out_valid}, 32'h0);
      bus.br_taken = 1'b0;
      cycle();
      check("br_tgt_pc", bus.inst_pc, 32'h0);

      // jump wins over branch
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_0010, 16'h0100, 26'h10);
      cycle();
      check("jmp_prio", bus.imem_adr, 32'h1000_0040);

      // misaligned branch target forced to word boundary
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 16'h0001, 26'h0);
      cycle();
      check("br_align", bus.imem_adr, 32'h0000_0104);

      // PC wrap at top of address space
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hF000_0000, 16'h0, 26'h3FF_FFFF);
      cycle();
      check("wrap_adr", bus.imem_adr, 32'hFFFF_FFFC);
      bus.jmp = 1'b0;
      cycle();
      check("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
      check("wrap_pc4", bus.pc_plus4, 32'h0);
      check("wrap_next", bus.imem_adr, 32'h0);

      // reset in the middle of a hold
      bus.out_ready = 1'b0;
      cycle();
      check("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
      rst = 1'b0;
      cycle();
      check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst_pc", bus.imem_adr, RESET_PC);
      check("rst_cnt", bus.fetch_cnt, 32'h0);
      rst = 1'b1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 15);
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
               (r == 0) || (r == 2), (r == 1) || (r == 2),
               $urandom, 16'($urandom), 26'($urandom));
         rst = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
